sdram_wb_scheduler: RTL

//  Shares the single SDRAM controller request port between the CPU Wishbone slave path and the DMA master.
//  It also sequences the controller handshake: one-cycle in_valid per access, hold while busy, and wait for out_valid on reads.
//  It routes ack and read data back to the winning master.

---
 rtl/sdram_sched_pkg.sv | 19 +
 rtl/sdram_sched_age.sv | 34 +++
 rtl/sdram_wb_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM Wishbone scheduler.
// FSM states, bus owner encoding and the read-timeout fill pattern.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT,
        ACK
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_sched_age.sv
// Aging arbiter: CPU normally wins, but after AGE_MAX consecutive
// CPU grants with DMA waiting, DMA is forced through.
module sdram_sched_age #(
    parameter int AGE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic win_dma
);

    localparam int AW = $clog2(AGE_MAX + 1);

    logic [AW-1:0] age;
    logic          aged_out;

    assign aged_out = (age >= AW'(AGE_MAX));
    assign win_dma  = dma_req && (!cpu_req || aged_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (grant_en) begin
            if (win_dma) begin
                age <= '0;
            end else if (cpu_req && dma_req && !aged_out) begin
                age <= age + AW'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_wb_scheduler.sv
// Arbitrates CPU and DMA Wishbone masters onto one SDRAM controller port
// and sequences the in_valid/busy/out_valid handshake per access.
module sdram_wb_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int          ADDR_W     = 23,
    parameter logic [7:0]  CPU_DEC    = 8'h38,
    parameter int          AGE_MAX    = 4,
    parameter int          RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_stb_i,
    input  logic              cpu_cyc_i,
    input  logic              cpu_we_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [31:0]       cpu_adr_i,
    input  logic [31:0]       cpu_dat_i,
    output logic              cpu_ack_o,
    output logic [31:0]       cpu_dat_o,
    input  logic              dma_stb_i,
    input  logic              dma_cyc_i,
    input  logic              dma_we_i,
    input  logic [3:0]        dma_sel_i,
    input  logic [31:0]       dma_adr_i,
    input  logic [31:0]       dma_dat_i,
    output logic              dma_ack_o,
    output logic [31:0]       dma_dat_o,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [31:0]       ctrl_wdata,
    output logic [3:0]        ctrl_mask,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic [31:0]       ctrl_rdata,
    input  logic              ctrl_out_valid,
    output logic              err_timeout
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    owner_t        owner;
    logic          cpu_req;
    logic          dma_req;
    logic          win_dma;
    logic          grant_en;
    logic          owner_cyc;
    logic          timeout;
    logic          rd_done;
    logic          orphan;
    logic [TW-1:0] timer;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign cpu_req   = cpu_stb_i && cpu_cyc_i && (cpu_adr_i[31:24] == CPU_DEC);
    assign dma_req   = dma_stb_i && dma_cyc_i;
    assign owner_cyc = (owner == OWN_DMA) ? dma_cyc_i : cpu_cyc_i;

    assign timeout = (state == RDWAIT) && (timer == TW'(RD_TIMEOUT - 1));
    assign rd_done = ctrl_out_valid || timeout;
    assign rd_val  = ctrl_out_valid ? ctrl_rdata : TIMEOUT_DATA;

    assign ctrl_in_valid = (state == ISSUE) && owner_cyc;
    assign cpu_ack_o     = (state == ACK) && (owner == OWN_CPU);
    assign dma_ack_o     = (state == ACK) && (owner == OWN_DMA);

    assign unused_bits = ^{cpu_adr_i, dma_adr_i};

    sdram_sched_age #(
        .AGE_MAX (AGE_MAX)
    ) u_age (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .grant_en (grant_en),
        .win_dma  (win_dma)
    );

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_en = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!owner_cyc) begin
                    state_nx = IDLE;
                end else if (!ctrl_busy) begin
                    state_nx = ctrl_rw ? ACK : RDWAIT;
                end
            end
            RDWAIT: begin
                // An abandoned read still drains the controller before idling
                if (rd_done) begin
                    state_nx = (orphan || !owner_cyc) ? IDLE : ACK;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            ctrl_addr   <= '0;
            ctrl_rw     <= 1'b0;
            ctrl_wdata  <= '0;
            ctrl_mask   <= '0;
            timer       <= '0;
            orphan      <= 1'b0;
            err_timeout <= 1'b0;
            cpu_dat_o   <= '0;
            dma_dat_o   <= '0;
        end else begin
            state       <= state_nx;
            err_timeout <= timeout && !ctrl_out_valid;
            if (grant_en) begin
                if (win_dma) begin
                    owner      <= OWN_DMA;
                    ctrl_addr  <= dma_adr_i[ADDR_W-1:0];
                    ctrl_rw    <= dma_we_i;
                    ctrl_wdata <= dma_dat_i;
                    ctrl_mask  <= dma_sel_i & {4{dma_we_i}};
                end else begin
                    owner      <= OWN_CPU;
                    ctrl_addr  <= cpu_adr_i[ADDR_W-1:0];
                    ctrl_rw    <= cpu_we_i;
                    ctrl_wdata <= cpu_dat_i;
                    ctrl_mask  <= cpu_sel_i & {4{cpu_we_i}};
                end
            end
            if (state == ISSUE) begin
                timer  <= '0;
                orphan <= 1'b0;
            end
            if (state == RDWAIT) begin
                timer <= timer + TW'(1);
                if (!owner_cyc) begin
                    orphan <= 1'b1;
                end
                if (state_nx == ACK) begin
                    if (owner == OWN_DMA) begin
                        dma_dat_o <= rd_val;
                    end else begin
                        cpu_dat_o <= rd_val;
                    end
                end
            end
        end
    end

endmodule
